// File: rtl/mac_rewrite_stage.sv
`default_nettype none
// ============================================================================
// mac_rewrite_stage : L2 header rewrite after an ARP lookup (fall-through FIFO).
// Optional macro RW_CHECKSUM_EN enables incremental IP checksum update.
// Revision: 1.0
// ============================================================================
module mac_rewrite_stage #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PORTS            = 4,
   parameter int FIFO_DEPTH_BITS      = 2,
   parameter int SRC_PORT_POS         = 16,
   parameter int DST_PORT_POS         = 24
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESET,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   input  logic                              S_AXIS_TLAST,
   output logic                              S_AXIS_TREADY,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   output logic                              M_AXIS_TLAST,
   input  logic                              M_AXIS_TREADY,
   input  logic                              lookup_valid,
   input  logic [47:0]                       dest_mac,
   input  logic                              arp_hit,
   input  logic [2*NUM_PORTS-1:0]            oq,
   output logic                              lookup_ack,
   input  logic [48*NUM_PORTS-1:0]           port_macs,
   input  logic                              counter_clear,
   output logic [31:0]                       forwarded_count,
   output logic [31:0]                       arp_miss_count,
   output logic [31:0]                       ttl_expired_count
);

   localparam int STRB_W  = C_S_AXIS_DATA_WIDTH / 8;
   localparam int ENTRY_W = C_S_AXIS_DATA_WIDTH + STRB_W + C_S_AXIS_TUSER_WIDTH + 1;
   localparam int DEPTH   = 1 << FIFO_DEPTH_BITS;
   localparam int PW      = 2 * NUM_PORTS;
   localparam logic [FIFO_DEPTH_BITS:0] NF_LVL = (FIFO_DEPTH_BITS + 1)'(DEPTH - 1);

   localparam logic [0:0] S_HEAD = 1'b0;
   localparam logic [0:0] S_BODY = 1'b1;

   logic [ENTRY_W-1:0]           mem_q [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_BITS:0]     count_q;
   logic [0:0]                   state_q, state_d;
   logic [31:0]                  fwd_cnt_q, miss_cnt_q, ttl_cnt_q;

   logic                              w_wr_en, w_rd_en, w_empty;
   logic [C_S_AXIS_DATA_WIDTH-1:0]    w_data;
   logic [STRB_W-1:0]                 w_strb;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_user;
   logic                              w_last;
   logic [PW-1:0]                     w_src, w_dst, w_cpu_dst;
   logic                              w_oq_ok, w_route_ok, w_fwd, w_ttl_exp, w_miss;
   logic [47:0]                       w_port_mac;
   logic [7:0]                        w_ttl;

   // ---------------- input FIFO (fall-through) ----------------
   assign w_empty       = (count_q == '0);
   assign S_AXIS_TREADY = (count_q < NF_LVL);
   assign w_wr_en       = S_AXIS_TVALID & S_AXIS_TREADY;
   assign w_rd_en       = M_AXIS_TVALID & M_AXIS_TREADY;
   assign {w_data, w_strb, w_user, w_last} = mem_q[rd_ptr_q];

   always_ff @(posedge AXI_ACLK) begin
      if (w_wr_en)
         mem_q[wr_ptr_q] <= {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
   end

   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (w_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({w_wr_en, w_rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------- header decision ----------------
   assign w_src = w_user[SRC_PORT_POS +: PW];
   assign w_dst = w_user[DST_PORT_POS +: PW];
   assign w_ttl = w_data[79:72];

   always_comb begin
      w_oq_ok    = $onehot(oq);
      w_port_mac = '0;
      w_cpu_dst  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (oq[2*i+1]) w_oq_ok = 1'b0;
         if (oq[2*i])   w_port_mac = port_macs[48*i +: 48];
         // only a single physical source port has a CPU queue to fall back to
         if ($onehot(w_src) && w_src[2*i]) w_cpu_dst[2*i+1] = 1'b1;
      end
   end

   assign w_route_ok = arp_hit & w_oq_ok;
   assign w_fwd      = (w_dst == '0) &  w_route_ok & (w_ttl > 8'd1);
   assign w_ttl_exp  = (w_dst == '0) &  w_route_ok & (w_ttl <= 8'd1);
   assign w_miss     = (w_dst == '0) & ~w_route_ok;

`ifdef RW_CHECKSUM_EN
   logic [16:0] w_csum_sum;
   logic [15:0] w_csum_new;
   assign w_csum_sum = {1'b0, w_data[63:48]} + 17'h00100;
   assign w_csum_new = w_csum_sum[15:0] + {15'd0, w_csum_sum[16]};
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) state_q <= S_HEAD;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_HEAD:  if (w_rd_en && !w_last) state_d = S_BODY;
         S_BODY:  if (w_rd_en &&  w_last) state_d = S_HEAD;
         default: state_d = S_HEAD;
      endcase
   end

   always_comb begin
      M_AXIS_TDATA  = w_data;
      M_AXIS_TSTRB  = w_strb;
      M_AXIS_TUSER  = w_user;
      M_AXIS_TLAST  = w_last;
      M_AXIS_TVALID = ~w_empty & ((state_q == S_HEAD) ? lookup_valid : 1'b1);
      lookup_ack    = 1'b0;
      if (state_q == S_HEAD) begin
         lookup_ack = M_AXIS_TVALID & M_AXIS_TREADY;
         if (w_fwd) begin
            M_AXIS_TUSER[DST_PORT_POS +: PW] = oq;
            M_AXIS_TDATA[255:208]            = dest_mac;
            M_AXIS_TDATA[207:160]            = w_port_mac;
            M_AXIS_TDATA[79:72]              = w_ttl - 8'd1;
`ifdef RW_CHECKSUM_EN
            M_AXIS_TDATA[63:48]              = w_csum_new;
`endif
         end else if (w_miss || w_ttl_exp) begin
            M_AXIS_TUSER[DST_PORT_POS +: PW] = w_cpu_dst;
         end
      end
   end

   // ---------------- saturating packet counters ----------------
   always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
      if (AXI_RESET) begin
         fwd_cnt_q  <= '0;
         miss_cnt_q <= '0;
         ttl_cnt_q  <= '0;
      end else if (counter_clear) begin
         fwd_cnt_q  <= '0;
         miss_cnt_q <= '0;
         ttl_cnt_q  <= '0;
      end else if (lookup_ack) begin
         if (w_fwd     && fwd_cnt_q  != 32'hFFFF_FFFF) fwd_cnt_q  <= fwd_cnt_q  + 32'd1;
         if (w_miss    && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (w_ttl_exp && ttl_cnt_q  != 32'hFFFF_FFFF) ttl_cnt_q  <= ttl_cnt_q  + 32'd1;
      end
   end

   assign forwarded_count   = fwd_cnt_q;
   assign arp_miss_count    = miss_cnt_q;
   assign ttl_expired_count = ttl_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_rewrite_stage.sv
`default_nettype none
// ============================================================================
// tb_mac_rewrite_stage : scoreboard bench for mac_rewrite_stage.
// Revision: 1.0
// ============================================================================
module tb_mac_rewrite_stage;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [255:0]  S_AXIS_TDATA = '0;
   logic [31:0]   S_AXIS_TSTRB = '0;
   logic [127:0]  S_AXIS_TUSER = '0;
   logic          S_AXIS_TVALID = 1'b0;
   logic          S_AXIS_TLAST = 1'b0;
   logic          S_AXIS_TREADY;
   logic [255:0]  M_AXIS_TDATA;
   logic [31:0]   M_AXIS_TSTRB;
   logic [127:0]  M_AXIS_TUSER;
   logic          M_AXIS_TVALID;
   logic          M_AXIS_TLAST;
   logic          M_AXIS_TREADY;
   logic          lookup_valid = 1'b0;
   logic [47:0]   dest_mac = '0;
   logic          arp_hit = 1'b0;
   logic [7:0]    oq = '0;
   logic          lookup_ack;
   logic [191:0]  port_macs;
   logic          counter_clear = 1'b0;
   logic [31:0]   forwarded_count, arp_miss_count, ttl_expired_count;

   logic ready_ctrl = 1'b1, tog_en = 1'b0, tog = 1'b0;
   assign M_AXIS_TREADY = tog_en ? tog : ready_ctrl;

   localparam logic [47:0] PMAC0 = 48'h02_00_00_AA_00_00;
   localparam logic [47:0] PMAC1 = 48'h02_00_00_AA_00_11;
   localparam logic [47:0] PMAC2 = 48'h02_00_00_AA_00_22;
   localparam logic [47:0] PMAC3 = 48'h02_00_00_AA_00_33;
   assign port_macs = {PMAC3, PMAC2, PMAC1, PMAC0};

`ifdef RW_CHECKSUM_EN
   localparam logic [15:0] CS_A = 16'hB2E6;
   localparam logic [15:0] CS_B = 16'h0100;
`else
   localparam logic [15:0] CS_A = 16'hB1E6;
   localparam logic [15:0] CS_B = 16'hFFFF;
`endif
   localparam logic [47:0] OLD_DM = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OLD_SM = 48'h1111_1111_1111;
   localparam logic [47:0] NEW_DM = 48'h0A0B_0C0D_0E0F;

   typedef struct {
      logic [255:0] d;
      logic [31:0]  s;
      logic [127:0] u;
      logic         l;
      logic         h;
   } beat_t;

   beat_t exp_q[$];
   int    vectors = 0;
   int    errors  = 0;

   mac_rewrite_stage dut (
      .AXI_ACLK          (clk),
      .AXI_RESET         (rst),
      .S_AXIS_TDATA      (S_AXIS_TDATA),
      .S_AXIS_TSTRB      (S_AXIS_TSTRB),
      .S_AXIS_TUSER      (S_AXIS_TUSER),
      .S_AXIS_TVALID     (S_AXIS_TVALID),
      .S_AXIS_TLAST      (S_AXIS_TLAST),
      .S_AXIS_TREADY     (S_AXIS_TREADY),
      .M_AXIS_TDATA      (M_AXIS_TDATA),
      .M_AXIS_TSTRB      (M_AXIS_TSTRB),
      .M_AXIS_TUSER      (M_AXIS_TUSER),
      .M_AXIS_TVALID     (M_AXIS_TVALID),
      .M_AXIS_TLAST      (M_AXIS_TLAST),
      .M_AXIS_TREADY     (M_AXIS_TREADY),
      .lookup_valid      (lookup_valid),
      .dest_mac          (dest_mac),
      .arp_hit           (arp_hit),
      .oq                (oq),
      .lookup_ack        (lookup_ack),
      .port_macs         (port_macs),
      .counter_clear     (counter_clear),
      .forwarded_count   (forwarded_count),
      .arp_miss_count    (arp_miss_count),
      .ttl_expired_count (ttl_expired_count)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1 tog = ~tog;
   end

   // Monitor: compares every accepted output beat against the scoreboard head.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat got data=%h user=%h", M_AXIS_TDATA, M_AXIS_TUSER);
               end else begin
                  e = exp_q.pop_front();
                  if (M_AXIS_TDATA !== e.d || M_AXIS_TUSER !== e.u || M_AXIS_TSTRB !== e.s ||
                      M_AXIS_TLAST !== e.l || lookup_ack !== e.h) begin
                     errors++;
                     $display("FAIL beat got data=%h user=%h strb=%h last=%b ack=%b exp data=%h user=%h strb=%h last=%b ack=%b",
                              M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST, lookup_ack,
                              e.d, e.u, e.s, e.l, e.h);
                  end
               end
            end else begin
               if (lookup_ack) begin
                  vectors++; errors++;
                  $display("FAIL stray_ack got lookup_ack=1 exp 0");
               end
               if (M_AXIS_TVALID && exp_q.size() != 0 &&
                   (M_AXIS_TDATA !== exp_q[0].d || M_AXIS_TUSER !== exp_q[0].u)) begin
                  vectors++; errors++;
                  $display("FAIL stall_hold got data=%h user=%h exp data=%h user=%h",
                           M_AXIS_TDATA, M_AXIS_TUSER, exp_q[0].d, exp_q[0].u);
               end
            end
         end
      end
   end

   function automatic logic [255:0] mk(input logic [31:0] seed, input logic [47:0] dm,
                                       input logic [47:0] sm, input logic [7:0] ttl,
                                       input logic [15:0] cs);
      logic [255:0] d;
      d          = {8{seed}};
      d[255:208] = dm;
      d[207:160] = sm;
      d[79:72]   = ttl;
      d[63:48]   = cs;
      return d;
   endfunction

   function automatic logic [127:0] usr(input logic [7:0] src, input logic [7:0] dst);
      return {96'h0123_4567_89AB_CDEF_0F1E_2D3C, dst, src, 16'h0040};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic chk_cnt(input logic [31:0] f, input logic [31:0] m, input logic [31:0] t);
      chk("forwarded_count", forwarded_count, f);
      chk("arp_miss_count", arp_miss_count, m);
      chk("ttl_expired_count", ttl_expired_count, t);
   endtask

   task automatic set_lu(input logic v, input logic [47:0] dm, input logic hit, input logic [7:0] q);
      lookup_valid = v;
      dest_mac     = dm;
      arp_hit      = hit;
      oq           = q;
   endtask

   task automatic push(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                       input logic l, input logic h);
      beat_t e;
      e.d = d; e.s = s; e.u = u; e.l = l; e.h = h;
      exp_q.push_back(e);
   endtask

   task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                            input logic l);
      int n;
      bit done;
      S_AXIS_TDATA  = d;
      S_AXIS_TSTRB  = s;
      S_AXIS_TUSER  = u;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      n = 0; done = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         if (S_AXIS_TREADY) done = 1;
         else n++;
      end
      @(posedge clk);
      #1 S_AXIS_TVALID = 1'b0;
      if (!done) begin
         vectors++; errors++;
         $display("FAIL s_axis_accept got timeout exp ready");
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++; errors++;
         $display("FAIL drain got %0d pending exp 0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pkt1(input logic [255:0] din, input logic [127:0] uin,
                       input logic [255:0] dexp, input logic [127:0] uexp);
      push(dexp, 32'hFFFF_FFFF, uexp, 1'b1, 1'b1);
      send_beat(din, 32'hFFFF_FFFF, uin, 1'b1);
      wait_drain();
   endtask

   initial begin
      logic [255:0] d;
      int n;

      // ---- reset state ----
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
      chk("rst_lookup_ack", {31'd0, lookup_ack}, 32'd0);
      chk("rst_s_tready", {31'd0, S_AXIS_TREADY}, 32'd1);
      chk_cnt(0, 0, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ---- forward: TTL 64 -> 63, port1 source MAC ----
      set_lu(1, NEW_DM, 1, 8'h04);
      pkt1(mk(32'hC0DE_0001, OLD_DM, OLD_SM, 8'd64, 16'hB1E6), usr(8'h01, 8'h00),
           mk(32'hC0DE_0001, NEW_DM, PMAC1, 8'd63, CS_A), usr(8'h01, 8'h04));
      chk_cnt(1, 0, 0);

      // ---- ARP miss: SRC 0x10 -> CPU queue 0x20 ----
      set_lu(1, NEW_DM, 0, 8'h04);
      d = mk(32'hC0DE_0002, OLD_DM, OLD_SM, 8'd64, 16'h1234);
      pkt1(d, usr(8'h10, 8'h00), d, usr(8'h10, 8'h20));
      chk_cnt(1, 1, 0);

      // ---- TTL expired ----
      set_lu(1, NEW_DM, 1, 8'h04);
      d = mk(32'hC0DE_0003, OLD_DM, OLD_SM, 8'd1, 16'h4321);
      pkt1(d, usr(8'h01, 8'h00), d, usr(8'h01, 8'h02));
      chk_cnt(1, 1, 1);

      // ---- nonzero DST passes untouched ----
      d = mk(32'hC0DE_0004, OLD_DM, OLD_SM, 8'd20, 16'h5555);
      pkt1(d, usr(8'h01, 8'h08), d, usr(8'h01, 8'h08));
      chk_cnt(1, 1, 1);

      // ---- oq on an odd (CPU) bit is a miss ----
      set_lu(1, NEW_DM, 1, 8'h02);
      d = mk(32'hC0DE_0005, OLD_DM, OLD_SM, 8'd20, 16'h6666);
      pkt1(d, usr(8'h04, 8'h00), d, usr(8'h04, 8'h08));
      chk_cnt(1, 2, 1);

      // ---- multi-hot oq is a miss ----
      set_lu(1, NEW_DM, 1, 8'h05);
      d = mk(32'hC0DE_0006, OLD_DM, OLD_SM, 8'd20, 16'h7777);
      pkt1(d, usr(8'h01, 8'h00), d, usr(8'h01, 8'h02));
      chk_cnt(1, 3, 1);

      // ---- multi-bit SRC: DST stays 0, counter still moves ----
      set_lu(1, NEW_DM, 0, 8'h04);
      d = mk(32'hC0DE_0007, OLD_DM, OLD_SM, 8'd20, 16'h8888);
      pkt1(d, usr(8'h05, 8'h00), d, usr(8'h05, 8'h00));
      chk_cnt(1, 4, 1);

      // ---- checksum wrap + 3-beat packet under toggling ready ----
      set_lu(1, NEW_DM, 1, 8'h40);
      tog_en = 1'b1;
      push(mk(32'hC0DE_0008, NEW_DM, PMAC3, 8'd9, CS_B), 32'hFFFF_FFFF, usr(8'h01, 8'h40), 1'b0, 1'b1);
      push({8{32'hB0D1_0001}}, 32'hFFFF_FFFF, usr(8'h01, 8'h00), 1'b0, 1'b0);
      push({8{32'hB0D1_0002}}, 32'h0000_FFFF, usr(8'h01, 8'h00), 1'b1, 1'b0);
      send_beat(mk(32'hC0DE_0008, OLD_DM, OLD_SM, 8'd10, 16'hFFFF), 32'hFFFF_FFFF, usr(8'h01, 8'h00), 1'b0);
      send_beat({8{32'hB0D1_0001}}, 32'hFFFF_FFFF, usr(8'h01, 8'h00), 1'b0);
      send_beat({8{32'hB0D1_0002}}, 32'h0000_FFFF, usr(8'h01, 8'h00), 1'b1);
      wait_drain();
      tog_en = 1'b0;
      chk_cnt(2, 4, 1);

      // ---- head held back while lookup_valid is low ----
      set_lu(0, NEW_DM, 1, 8'h01);
      push(mk(32'hC0DE_0009, NEW_DM, PMAC0, 8'd4, CS_A), 32'hFFFF_FFFF, usr(8'h02, 8'h01), 1'b1, 1'b1);
      send_beat(mk(32'hC0DE_0009, OLD_DM, OLD_SM, 8'd5, 16'hB1E6), 32'hFFFF_FFFF, usr(8'h02, 8'h00), 1'b1);
      repeat (4) @(posedge clk);
      #1;
      chk("gated_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
      chk("gated_pending", exp_q.size(), 32'd1);
      lookup_valid = 1'b1;
      wait_drain();
      chk_cnt(3, 4, 1);

      // ---- saturation of the miss counter ----
      force dut.miss_cnt_q = 32'hFFFF_FFFF;
      #1 release dut.miss_cnt_q;
      set_lu(1, NEW_DM, 0, 8'h04);
      d = mk(32'hC0DE_000A, OLD_DM, OLD_SM, 8'd20, 16'h9999);
      pkt1(d, usr(8'h01, 8'h00), d, usr(8'h01, 8'h02));
      chk("miss_saturated", arp_miss_count, 32'hFFFF_FFFF);

      // ---- clear wins over a simultaneous miss ----
      ready_ctrl = 1'b0;
      d = mk(32'hC0DE_000B, OLD_DM, OLD_SM, 8'd20, 16'hAAAA);
      push(d, 32'hFFFF_FFFF, usr(8'h40, 8'h80), 1'b1, 1'b1);
      send_beat(d, 32'hFFFF_FFFF, usr(8'h40, 8'h00), 1'b1);
      n = 0;
      while (!M_AXIS_TVALID && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      ready_ctrl    = 1'b1;
      counter_clear = 1'b1;
      @(posedge clk);
      #1 counter_clear = 1'b0;
      wait_drain();
      chk_cnt(0, 0, 0);

      // ---- reset mid-packet, next beat is a head ----
      set_lu(1, NEW_DM, 1, 8'h10);
      push(mk(32'hC0DE_000C, NEW_DM, PMAC2, 8'd7, CS_A), 32'hFFFF_FFFF, usr(8'h01, 8'h10), 1'b0, 1'b1);
      send_beat(mk(32'hC0DE_000C, OLD_DM, OLD_SM, 8'd8, 16'hB1E6), 32'hFFFF_FFFF, usr(8'h01, 8'h00), 1'b0);
      wait_drain();
      ready_ctrl = 1'b0;
      send_beat({8{32'hDEAD_BEEF}}, 32'hFFFF_FFFF, usr(8'h01, 8'h00), 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("midrst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
      chk("midrst_ack", {31'd0, lookup_ack}, 32'd0);
      chk_cnt(0, 0, 0);
      rst = 1'b0;
      ready_ctrl = 1'b1;
      @(posedge clk); #1;
      set_lu(1, NEW_DM, 1, 8'h04);
      pkt1(mk(32'hC0DE_000D, OLD_DM, OLD_SM, 8'd64, 16'hB1E6), usr(8'h01, 8'h00),
           mk(32'hC0DE_000D, NEW_DM, PMAC1, 8'd63, CS_A), usr(8'h01, 8'h04));
      chk_cnt(1, 0, 0);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
